// File: rtl/sgd_defines.sv
// Shared beat layout for the SGD work send/receive paths: one index word,
// a reserved gap, and NUM_OF_BANKS signed 32-bit dot products in the low bits.
package sgd_defines;

    localparam int          NUM_OF_BANKS = 8;
    localparam logic [31:0] INDEX_MAX    = 32'h7f;
    localparam int          NET_W        = 512;
    localparam int          KEEP_W       = NET_W / 8;
    localparam int          RSV_W        = NET_W - 32 - 32 * NUM_OF_BANKS;

    typedef logic signed [31:0] dot_t;

    typedef struct packed {
        logic [31:0]                   index;
        logic [RSV_W-1:0]              reserved;
        logic [NUM_OF_BANKS-1:0][31:0] bank;
    } net_beat_t;

    typedef struct packed {
        logic [31:0]                   index;
        logic [NUM_OF_BANKS-1:0][31:0] bank;
    } result_t;

    localparam int RESULT_W = $bits(result_t);

    // The sender emits the network word with byte 0 on the wire first.
    function automatic logic [NET_W-1:0] byte_reverse(input logic [NET_W-1:0] d);
        logic [NET_W-1:0] r;
        r = '0;
        for (int i = 0; i < KEEP_W; i++) begin
            r[NET_W-1-8*i -: 8] = d[8*i +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/distram_fifo.sv
// Distributed-RAM FIFO with a first-word-fall-through output register.
// count_o covers the memory plus the output register.
module distram_fifo #(
    parameter int WIDTH      = 32,
    parameter int DEPTH_BITS = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en_i,
    input  logic [WIDTH-1:0]      wr_data_i,
    input  logic                  rd_en_i,
    output logic [WIDTH-1:0]      rd_data_o,
    output logic                  valid_o,
    output logic [DEPTH_BITS:0]   count_o
);

    localparam int DEPTH = 1 << DEPTH_BITS;

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [DEPTH_BITS-1:0] wr_ptr_q, rd_ptr_q;
    logic [DEPTH_BITS:0]   mem_cnt_q, mem_cnt_d;
    logic                  out_vld_q, out_vld_d;
    logic [WIDTH-1:0]      out_data_q;
    logic                  pop, load, full;

    assign pop  = rd_en_i & out_vld_q;
    assign load = (mem_cnt_q != '0) & (~out_vld_q | pop);

    always_comb begin
        mem_cnt_d = mem_cnt_q;
        if (wr_en_i && !load) begin
            mem_cnt_d = mem_cnt_q + (DEPTH_BITS+1)'(1);
        end else if (!wr_en_i && load) begin
            mem_cnt_d = mem_cnt_q - (DEPTH_BITS+1)'(1);
        end
        out_vld_d = load | (out_vld_q & ~pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            mem_cnt_q  <= '0;
            out_vld_q  <= 1'b0;
            out_data_q <= '0;
        end else begin
            if (wr_en_i) wr_ptr_q <= wr_ptr_q + DEPTH_BITS'(1);
            if (load) begin
                rd_ptr_q   <= rd_ptr_q + DEPTH_BITS'(1);
                out_data_q <= mem_q[rd_ptr_q];
            end
            mem_cnt_q <= mem_cnt_d;
            out_vld_q <= out_vld_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en_i) mem_q[wr_ptr_q] <= wr_data_i;
    end

    assign count_o   = mem_cnt_q + {{DEPTH_BITS{1'b0}}, out_vld_q};
    assign full      = (count_o == (DEPTH_BITS+1)'(DEPTH));
    assign rd_data_o = out_data_q;
    assign valid_o   = out_vld_q;

    no_write_when_full: assert property (@(posedge clk) disable iff (rst) !(wr_en_i && full));

endmodule

// File: rtl/sgd_work_recv.sv
// Receives byte-reversed SGD dot-product beats, checks the index sequence and
// buffers results for the gradient-update engines.
module sgd_work_recv
    import sgd_defines::*;
#(
    parameter int FIFO_DEPTH_BITS = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NET_W-1:0]    s_axis_rx_data_tdata,
    input  logic [KEEP_W-1:0]   s_axis_rx_data_tkeep,
    input  logic                s_axis_rx_data_tlast,
    input  logic                s_axis_rx_data_tvalid,
    output logic                s_axis_rx_data_tready,
    output dot_t                dot_product_signed [NUM_OF_BANKS],
    output logic [31:0]         dot_product_index,
    output logic                dot_product_valid,
    input  logic                dot_product_ready,
    output logic [31:0]         seq_err_cnt,
    output logic [31:0]         malformed_cnt,
    output logic [31:0]         beat_cnt
);

    localparam int DEPTH = 1 << FIFO_DEPTH_BITS;
    localparam int CW    = FIFO_DEPTH_BITS + 2;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

    function automatic logic [31:0] next_index(input logic [31:0] idx);
        return (idx >= INDEX_MAX) ? 32'd0 : idx + 32'd1;
    endfunction

    net_beat_t beat;
    logic      accept, well_formed, wr_ok, idx_match, unused_rsv;
    logic      ready_q, ready_d;
    logic [31:0] exp_idx_q, exp_idx_d;
    logic [31:0] seq_err_q, seq_err_d, mal_q, mal_d, beat_q, beat_d;
    logic      up_vld_q;
    result_t   up_data_q, rd_res;
    logic [RESULT_W-1:0]      rd_data;
    logic [FIFO_DEPTH_BITS:0] fifo_cnt;
    logic [CW-1:0]            committed;

    assign beat        = net_beat_t'(byte_reverse(s_axis_rx_data_tdata));
    assign unused_rsv  = ^beat.reserved;
    assign accept      = s_axis_rx_data_tvalid & ready_q;
    assign well_formed = (&s_axis_rx_data_tkeep) & s_axis_rx_data_tlast;
    assign wr_ok       = accept & well_formed;
    assign idx_match   = (beat.index == exp_idx_q);

    // A mismatch still resyncs to the received index so one gap counts once.
    always_comb begin
        exp_idx_d = exp_idx_q;
        seq_err_d = seq_err_q;
        mal_d     = mal_q;
        beat_d    = beat_q;
        if (accept && !well_formed) mal_d = sat_inc(mal_q);
        if (wr_ok) begin
            beat_d    = sat_inc(beat_q);
            exp_idx_d = next_index(beat.index);
            if (!idx_match) seq_err_d = sat_inc(seq_err_q);
        end
    end

    // Every result already committed (FIFO, unpack stage, this cycle's accept)
    // is counted, so ready falls with two slots still free.
    assign committed = CW'(fifo_cnt) + CW'(up_vld_q) + CW'(wr_ok);
    assign ready_d   = (committed < CW'(DEPTH - 2));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_q   <= 1'b0;
            exp_idx_q <= '0;
            seq_err_q <= '0;
            mal_q     <= '0;
            beat_q    <= '0;
            up_vld_q  <= 1'b0;
        end else begin
            ready_q   <= ready_d;
            exp_idx_q <= exp_idx_d;
            seq_err_q <= seq_err_d;
            mal_q     <= mal_d;
            beat_q    <= beat_d;
            up_vld_q  <= wr_ok;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            up_data_q.index <= beat.index;
            up_data_q.bank  <= beat.bank;
        end
    end

    distram_fifo #(
        .WIDTH      (RESULT_W),
        .DEPTH_BITS (FIFO_DEPTH_BITS)
    ) u_result_fifo (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (up_vld_q),
        .wr_data_i (up_data_q),
        .rd_en_i   (dot_product_ready),
        .rd_data_o (rd_data),
        .valid_o   (dot_product_valid),
        .count_o   (fifo_cnt)
    );

    assign rd_res = result_t'(rd_data);

    always_comb begin
        for (int k = 0; k < NUM_OF_BANKS; k++) begin
            dot_product_signed[k] = dot_t'(rd_res.bank[k]);
        end
    end

    assign dot_product_index     = rd_res.index;
    assign s_axis_rx_data_tready = ready_q;
    assign seq_err_cnt           = seq_err_q;
    assign malformed_cnt         = mal_q;
    assign beat_cnt              = beat_q;

endmodule

// File: tb/tb_sgd_work_recv.sv
// Directed bench for sgd_work_recv: latency, sequencing, malformed beats,
// back-pressure and asynchronous reset.
module tb_sgd_work_recv;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst;
    logic [511:0]       tdata;
    logic [63:0]        tkeep;
    logic               tlast, tvalid, tready;
    logic signed [31:0] dps [8];
    logic [31:0]        dpi, serr, mal, bcnt;
    logic               dpv, dpr;

    int n_tests = 0;
    int n_fail  = 0;
    logic [287:0] sb [$];

    sgd_work_recv #(.FIFO_DEPTH_BITS(6)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .s_axis_rx_data_tdata  (tdata),
        .s_axis_rx_data_tkeep  (tkeep),
        .s_axis_rx_data_tlast  (tlast),
        .s_axis_rx_data_tvalid (tvalid),
        .s_axis_rx_data_tready (tready),
        .dot_product_signed    (dps),
        .dot_product_index     (dpi),
        .dot_product_valid     (dpv),
        .dot_product_ready     (dpr),
        .seq_err_cnt           (serr),
        .malformed_cnt         (mal),
        .beat_cnt              (bcnt)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [511:0] make_data(input logic [31:0] idx, input logic [255:0] banks);
        logic [511:0] net;
        logic [511:0] d;
        net = {idx, {7{32'hA5C3_0F96}}, banks};
        for (int i = 0; i < 64; i++) d[8*i +: 8] = net[8*(63-i) +: 8];
        return d;
    endfunction

    function automatic logic [255:0] stream_banks(input logic [31:0] idx, input int ser);
        logic [255:0] b;
        for (int k = 0; k < 8; k++) b[32*k +: 32] = {4'(k) ^ 4'h8, 12'(ser), idx[15:0]};
        return b;
    endfunction

    task automatic tick();
        logic [287:0] e;
        if (dpv && dpr) begin
            check_val("sb_nonempty", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check_val("out_index", dpi, e[287:256]);
                for (int k = 0; k < 8; k++) check_val("out_bank", dps[k], e[32*k +: 32]);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] idx, input logic [255:0] banks,
                        input logic [63:0] keep, input logic last);
        int n;
        n = 0;
        tdata  = make_data(idx, banks);
        tkeep  = keep;
        tlast  = last;
        tvalid = 1'b1;
        while (!tready && n < 200) begin
            tick();
            n++;
        end
        check_val("send_rdy", 32'(tready), 32'd1);
        if (tready) begin
            if (keep == '1 && last) sb.push_back({idx, banks});
            tick();
        end
        tvalid = 1'b0;
    endtask

    task automatic drain(input int max);
        int n;
        n = 0;
        while (sb.size() > 0 && n < max) begin
            tick();
            n++;
        end
        check_val("drain_done", 32'(sb.size()), 32'd0);
    endtask

    task automatic do_reset();
        int n;
        n = 0;
        rst = 1'b1;
        #1;
        check_val("rst_valid", 32'(dpv), 32'd0);
        check_val("rst_ready", 32'(tready), 32'd0);
        check_val("rst_index", dpi, 32'd0);
        check_val("rst_bank0", dps[0], 32'd0);
        check_val("rst_serr", serr, 32'd0);
        check_val("rst_mal", mal, 32'd0);
        check_val("rst_bcnt", bcnt, 32'd0);
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        while (!tready && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_val("rst_rdy_up", 32'(tready), 32'd1);
    endtask

    task automatic test_single();
        logic [255:0] b;
        b = {32'h50, 32'h40, 32'h30, 32'h20, 32'h10, 32'h0, 32'hffff_fff0, 32'hffff_ffe0};
        do_reset();
        dpr = 1'b1;
        send(32'd0, b, '1, 1'b1);
        check_val("t1_bcnt", bcnt, 32'd1);
        check_val("t1_serr", serr, 32'd0);
        check_val("lat_t1", 32'(dpv), 32'd0);
        tick();
        check_val("lat_t2", 32'(dpv), 32'd0);
        tick();
        check_val("lat_t3", 32'(dpv), 32'd1);
        check_val("t1_index", dpi, 32'd0);
        check_val("t1_bank0", dps[0], 32'hffff_ffe0);
        check_val("t1_bank1", dps[1], 32'hffff_fff0);
        check_val("t1_bank2", dps[2], 32'h0);
        check_val("t1_bank7", dps[7], 32'h50);
        tick();
        check_val("t1_empty", 32'(dpv), 32'd0);
        check_val("t1_hold", dps[7], 32'h50);
    endtask

    task automatic test_stream();
        logic [31:0] idx;
        do_reset();
        dpr = 1'b1;
        for (int i = 0; i < 130; i++) begin
            idx = 32'(i % 128);
            send(idx, stream_banks(idx, i), '1, 1'b1);
        end
        drain(20);
        check_val("t2_serr", serr, 32'd0);
        check_val("t2_bcnt", bcnt, 32'd130);
        check_val("t2_mal", mal, 32'd0);
    endtask

    task automatic test_seq_and_malformed();
        do_reset();
        dpr = 1'b1;
        send(32'd0, stream_banks(32'd0, 300), '1, 1'b1);
        send(32'd1, stream_banks(32'd1, 301), '1, 1'b1);
        check_val("t3_serr_a", serr, 32'd0);
        send(32'd5, stream_banks(32'd5, 302), '1, 1'b1);
        check_val("t3_serr_b", serr, 32'd1);
        send(32'd6, stream_banks(32'd6, 303), '1, 1'b1);
        check_val("t3_serr_c", serr, 32'd1);
        drain(20);
        check_val("t3_bcnt", bcnt, 32'd4);
        send(32'd7, stream_banks(32'd7, 304), 64'h00ff_ffff_ffff_ffff, 1'b1);
        send(32'd7, stream_banks(32'd7, 305), '1, 1'b0);
        check_val("t4_mal", mal, 32'd2);
        check_val("t4_bcnt", bcnt, 32'd4);
        for (int i = 0; i < 5; i++) tick();
        check_val("t4_nodeliv", 32'(dpv), 32'd0);
        send(32'd7, stream_banks(32'd7, 306), '1, 1'b1);
        check_val("t4_serr", serr, 32'd1);
        check_val("t4_bcnt2", bcnt, 32'd5);
        drain(20);
    endtask

    task automatic test_backpressure();
        int acc;
        logic [255:0] bk;
        do_reset();
        dpr    = 1'b0;
        acc    = 0;
        tkeep  = '1;
        tlast  = 1'b1;
        tvalid = 1'b1;
        for (int c = 0; c < 100; c++) begin
            bk    = stream_banks(32'(acc), acc + 1000);
            tdata = make_data(32'(acc), bk);
            if (tready) begin
                sb.push_back({32'(acc), bk});
                acc++;
            end
            tick();
        end
        tvalid = 1'b0;
        check_val("t5_accepted", 32'(acc), 32'd62);
        check_val("t5_rdy_low", 32'(tready), 32'd0);
        check_val("t5_vld", 32'(dpv), 32'd1);
        for (int i = 0; i < 5; i++) tick();
        check_val("t5_stall_vld", 32'(dpv), 32'd1);
        check_val("t5_stall_idx", dpi, 32'd0);
        check_val("t5_stall_bank3", dps[3], 32'hB3E8_0000);
        dpr = 1'b1;
        for (int i = 0; i < 62; i++) begin
            check_val("t5_drain_vld", 32'(dpv), 32'd1);
            tick();
        end
        check_val("t5_empty", 32'(dpv), 32'd0);
        check_val("t5_sb_empty", 32'(sb.size()), 32'd0);
        check_val("t5_rdy_back", 32'(tready), 32'd1);
    endtask

    task automatic test_reset_midstream();
        do_reset();
        dpr = 1'b0;
        for (int i = 0; i < 10; i++) send(32'(i), stream_banks(32'(i), 500 + i), '1, 1'b1);
        for (int i = 0; i < 4; i++) tick();
        check_val("t6_buffered", 32'(dpv), 32'd1);
        check_val("t6_bcnt_pre", bcnt, 32'd10);
        do_reset();
        dpr = 1'b1;
        send(32'd0, stream_banks(32'd0, 600), '1, 1'b1);
        drain(10);
        check_val("t6_serr", serr, 32'd0);
        check_val("t6_bcnt", bcnt, 32'd1);
        for (int i = 0; i < 3; i++) tick();
        check_val("t6_no_stale", 32'(dpv), 32'd0);
    endtask

    initial begin
        rst    = 1'b0;
        tvalid = 1'b0;
        tdata  = '0;
        tkeep  = '0;
        tlast  = 1'b0;
        dpr    = 1'b0;
        #2;
        test_single();
        test_stream();
        test_seq_and_malformed();
        test_backpressure();
        test_reset_midstream();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/sgd_work_recv.md
Name: sgd_work_recv

Overview:
- Network-side receiver for the per-bank dot-product beats produced by the SGD work-send path.
- Accepts 512-bit AXI-Stream beats, undoes the byte reversal and unpacks the sequence index plus NUM_OF_BANKS signed 32-bit dot products.
- Checks the index sequence, buffers results in a FIFO, and presents them to the gradient-update engines through a valid/ready handshake with status counters.

Parameters:
- NUM_OF_BANKS, 8, number of 32-bit dot-product lanes per beat (occupies net bits [32*NUM_OF_BANKS-1:0]).
- INDEX_MAX, 32'h7f, last index before the sender's sequence wraps to 0.
- FIFO_DEPTH_BITS, 6, log2 of result FIFO depth (64 entries).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- s_axis_rx_data  axi_stream.slave  512 data/64 keep/1 last  incoming beats; module drives ready
- dot_product_signed  out  NUM_OF_BANKS x 32 (signed)  unpacked dot products
- dot_product_index  out  32  sequence index of the presented result
- dot_product_valid  out  1  result valid
- dot_product_ready  in  1  consumer accepts result
- seq_err_cnt  out  32  index-mismatch count, saturating
- malformed_cnt  out  32  dropped-beat count, saturating
- beat_cnt  out  32  accepted-beat count, saturating

Behaviour:
- Reset (async, rst=1): ready=0, dot_product_valid=0, dot_product_signed=0, dot_product_index=0, all counters=0, expected index=0, FIFO emptied. Reset mid-transfer discards all buffered results.
- Unpack: net[511-8i -: 8] = data[8i+7:8i] for i=0..63. Index = net[511:480], bank k = net[32k+31:32k], net[479:256] ignored.
- Accept = valid & ready. ready is registered: 1 when FIFO free slots > 2 on the previous cycle, else 0. This covers the one beat in flight in the unpack stage; the FIFO never overflows.
- Accepted beat with keep != all-ones or last=0: dropped. malformed_cnt+1. Expected index unchanged. Nothing written to FIFO.
- Well-formed beat: beat_cnt+1. Compare index with expected.
  - Equal: expected <= (index >= INDEX_MAX) ? 0 : index+1.
  - Not equal: seq_err_cnt+1; resync expected from the received index using the same rule. The data is still delivered.
- Pipeline: cycle T accept -> T+1 unpack register -> T+2 FIFO write -> T+3 dot_product_valid (FIFO previously empty, first-word-fall-through output register). Latency is exactly 3 cycles.
- Output handshake: while valid & !ready, data and index hold stable. A pop occurs on valid & ready. Back-to-back pops sustain 1 result/cycle.
- FIFO full: unreachable by construction. Assertion required: no write when full.
- Empty with ready=1: valid=0, outputs hold their last value.
- Simultaneous FIFO write and read: both occur; count unchanged.
- Counters saturate at 32'hffff_ffff and never wrap.

Decomposition:
- Shared package (sgd_defines): NUM_OF_BANKS, INDEX_MAX and a packed struct for the beat layout (index, reserved 224 bits, bank array). The unpacker and the sender share one field map.
- One sub-module: the existing distram_fifo, instantiated as the result buffer (width 32 + 32*NUM_OF_BANKS, FIFO_DEPTH_BITS). The sequence checker and unpack stage live in the top module.

Test Plan:
- Single beat, index 0, banks k=0..7 set to k*0x10 - 0x20 (bank0 = 0xffffffe0), sent byte-reversed; consumer ready=1 -> at T+3 valid=1, index=0, banks match, seq_err_cnt=0, beat_cnt=1.
- Stream of 130 beats, indices 0..0x7f then 0,1 -> all delivered in order, seq_err_cnt=0.
- Sequence 0,1,5,6 -> seq_err_cnt=1 at index 5; all four delivered; no further errors after 6.
- Beat with keep=64'h00ff..ff, then one with last=0 -> malformed_cnt=2, beat_cnt unchanged, nothing delivered, expected index unchanged.
- Consumer ready=0, sender valid continuously -> ready drops with exactly 62 results buffered, no loss. Ready=1 -> 62 results drained in order at 1/cycle, then ready reasserts. Outputs stable while stalled.
- Async reset pulse mid-stream with 10 results buffered -> valid=0 and counters=0 immediately. Post-reset beat with index 0 gives no sequence error.
